// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler: round-robin arbiter sharing one shift-add unsigned multiplier among NREQ requesters
module mul_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_flat,
  input  logic [NREQ*WIDTH-1:0] b_flat,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [2*WIDTH-1:0]    y,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] last, cur_id, sel;
  logic found;
  logic [WIDTH-1:0] a_sel, b_sel, mplier;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [CW-1:0] count;
  int idx;
  // Search starts just after the last served requester, wrapping around.
  always_comb begin
    gnt = '0;
    sel = last;
    found = 1'b0;
    a_sel = '0;
    b_sel = '0;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      idx = idx >= NREQ ? idx - NREQ : idx;
      if (!found && state == IDLE && req[idx]) begin
        found = 1'b1;
        sel = ID_W'(idx);
        gnt[idx] = 1'b1;
        a_sel = a_flat[idx*WIDTH +: WIDTH];
        b_sel = b_flat[idx*WIDTH +: WIDTH];
      end
    end
  end
  always_comb begin
    state_n = state == IDLE ? (found ? BUSY : IDLE) :
              state == BUSY ? (count == CW'(WIDTH-1) ? DONE : BUSY) : IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= ID_W'(NREQ-1);
      cur_id     <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
      y          <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
    end else begin
      state      <= state_n;
      resp_valid <= state == DONE;
      if (state == IDLE && found) begin
        mcand  <= {{WIDTH{1'b0}}, a_sel};
        mplier <= b_sel;
        acc    <= '0;
        count  <= '0;
        cur_id <= sel;
        last   <= sel;
      end
      if (state == BUSY) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end
      if (state == DONE) begin
        y       <= acc;
        resp_id <= cur_id;
      end
    end
  end
endmodule
